// File: rtl/trap_seq.sv
`default_nettype none
// trap_seq - machine-mode trap/mret sequencer driving the single-port CSR interface. Rev 1.0
// Optional TRAP_SEQ_MIP_EN: interrupt traps also clear their pending bit in mip before redirecting.
module trap_seq #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  output logic [11:0] csr_addr,
  output logic [1:0]  csr_op,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0]  CSR_NOP   = 2'd0;
  localparam logic [1:0]  CSR_WRITE = 2'd1;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;
`ifdef TRAP_SEQ_MIP_EN
  localparam logic [1:0]  CSR_CLEAR = 2'd3;
  localparam logic [11:0] ADDR_MIP  = 12'h344;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_TVAL   = 3'd3,
    ST_R_EPC    = 3'd4,
    ST_R_WAIT   = 3'd5,
    ST_REDIRECT = 3'd6
`ifdef TRAP_SEQ_MIP_EN
    ,
    ST_W_MIP    = 3'd7
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      pc_q           <= 32'h0;
      cause_q        <= 32'h0;
      tval_q         <= 32'h0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Trap has priority; a simultaneous mret stays pending at the requester.
          if (trap_req) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
            tval_q  <= trap_tval;
            state   <= ST_W_EPC;
          end else if (mret_req) begin
            state <= ST_R_EPC;
          end
        end
        ST_W_EPC:   state <= ST_W_CAUSE;
        ST_W_CAUSE: state <= ST_W_TVAL;
        ST_W_TVAL: begin
`ifdef TRAP_SEQ_MIP_EN
          if (cause_q[31]) begin
            state <= ST_W_MIP;
          end else begin
            redirect_valid <= 1'b1;
            redirect_pc    <= TRAP_VECTOR;
            state          <= ST_REDIRECT;
          end
`else
          redirect_valid <= 1'b1;
          redirect_pc    <= TRAP_VECTOR;
          state          <= ST_REDIRECT;
`endif
        end
`ifdef TRAP_SEQ_MIP_EN
        ST_W_MIP: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= TRAP_VECTOR;
          state          <= ST_REDIRECT;
        end
`endif
        ST_R_EPC:   state <= ST_R_WAIT;
        ST_R_WAIT: begin
          // Read data is registered by the CSR file, so it is valid only now.
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_rdata & 32'hFFFF_FFFC;
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_addr  = 12'h0;
    csr_op    = CSR_NOP;
    csr_wdata = 32'h0;
    case (state)
      ST_W_EPC: begin
        csr_addr  = ADDR_MEPC;
        csr_op    = CSR_WRITE;
        csr_wdata = pc_q;
      end
      ST_W_CAUSE: begin
        csr_addr  = ADDR_MCAUSE;
        csr_op    = CSR_WRITE;
        csr_wdata = cause_q;
      end
      ST_W_TVAL: begin
        csr_addr  = ADDR_MTVAL;
        csr_op    = CSR_WRITE;
        csr_wdata = tval_q;
      end
`ifdef TRAP_SEQ_MIP_EN
      ST_W_MIP: begin
        csr_addr  = ADDR_MIP;
        csr_op    = CSR_CLEAR;
        csr_wdata = 32'h1 << cause_q[4:0];
      end
`endif
      ST_R_EPC, ST_R_WAIT: begin
        csr_addr = ADDR_MEPC;
      end
      default: begin
        csr_addr  = 12'h0;
        csr_op    = CSR_NOP;
        csr_wdata = 32'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_seq.sv
`default_nettype none
// tb_trap_seq - scoreboard bench for trap_seq with a CSR register-file responder.
module tb_trap_seq;

  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0010;
  localparam logic [1:0]  OP_NOP   = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [1:0]  OP_SET   = 2'd2;
  localparam logic [1:0]  OP_CLEAR = 2'd3;
  localparam int          MAXC     = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_tval = '0;
  logic        mret_req = 1'b0;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  trap_seq #(.TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .mret_req(mret_req),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR register file: writes commit at the edge, read data is registered.
  logic [31:0] csr_mem [0:4095];
  initial for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
  always @(posedge clk) begin
    if (csr_op == OP_WRITE)      csr_mem[csr_addr] <= csr_wdata;
    else if (csr_op == OP_SET)   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
    else if (csr_op == OP_CLEAR) csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
    csr_rdata <= csr_mem[csr_addr];
  end

  typedef struct {
    int          c;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] data;
  } csr_exp_t;
  typedef struct {
    int          c;
    logic [31:0] pc;
  } rd_exp_t;

  csr_exp_t    csr_q[$];
  rd_exp_t     rd_q[$];
  bit          busy_map [0:MAXC-1];
  int          model_idle = 0;
  logic [31:0] ref_mepc = '0;
  logic [31:0] last_rpc = '0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic push_csr(input int c, input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_exp_t e;
    e.c = c; e.addr = a; e.op = op; e.data = d;
    csr_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [31:0] pc);
    rd_exp_t e;
    e.c = c; e.pc = pc;
    rd_q.push_back(e);
  endtask

  task automatic mark_busy(input int from, input int to);
    for (int c = from; c < to; c++) if (c < MAXC) busy_map[c] = 1'b1;
  endtask

  // Trap accepted at edge t: three writes, optional mip clear, redirect, then idle.
  task automatic model_trap(input int t, input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] tval);
    int len;
    len = 4;
    push_csr(t,     12'h341, OP_WRITE, pc);
    push_csr(t + 1, 12'h342, OP_WRITE, cause);
    push_csr(t + 2, 12'h343, OP_WRITE, tval);
`ifdef TRAP_SEQ_MIP_EN
    if (cause[31]) begin
      push_csr(t + 3, 12'h344, OP_CLEAR, 32'h1 << cause[4:0]);
      len = 5;
    end
`endif
    push_rd(t + len - 1, TRAP_VECTOR);
    mark_busy(t, t + len);
    model_idle = t + len;
    ref_mepc = pc;
  endtask

  task automatic model_mret(input int t);
    push_csr(t,     12'h341, OP_NOP, 32'h0);
    push_csr(t + 1, 12'h341, OP_NOP, 32'h0);
    push_rd(t + 2, {ref_mepc[31:2], 2'b00});
    mark_busy(t, t + 3);
    model_idle = t + 3;
  endtask

  // Monitor: pops scoreboard entries as the DUT reaches them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (csr_q.size() > 0 && csr_q[0].c < cyc) begin
        chk("csr_missed", cyc, csr_q[0].c);
        void'(csr_q.pop_front());
      end
      if (csr_q.size() > 0 && csr_q[0].c == cyc) begin
        csr_exp_t e;
        e = csr_q.pop_front();
        chk("csr_addr", {20'h0, csr_addr}, {20'h0, e.addr});
        chk("csr_op", {30'h0, csr_op}, {30'h0, e.op});
        chk("csr_wdata", csr_wdata, e.data);
      end else begin
        chk("csr_addr_idle", {20'h0, csr_addr}, 32'h0);
        chk("csr_op_idle", {30'h0, csr_op}, {30'h0, OP_NOP});
        chk("csr_wdata_idle", csr_wdata, 32'h0);
      end
      if (rd_q.size() > 0 && rd_q[0].c < cyc) begin
        chk("redirect_missed", cyc, rd_q[0].c);
        void'(rd_q.pop_front());
      end
      if (rd_q.size() > 0 && rd_q[0].c == cyc) begin
        rd_exp_t r;
        r = rd_q.pop_front();
        chk("redirect_valid", {31'h0, redirect_valid}, 32'h1);
        chk("redirect_pc", redirect_pc, r.pc);
        last_rpc = r.pc;
      end else begin
        chk("redirect_valid_idle", {31'h0, redirect_valid}, 32'h0);
        chk("redirect_pc_hold", redirect_pc, last_rpc);
      end
      chk("busy", {31'h0, busy}, {31'h0, (cyc < MAXC) ? busy_map[cyc] : 1'b0});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int gap);
    while (cyc < model_idle + gap) tick();
  endtask

  // Issue a request once the model says IDLE; scramble payloads right after acceptance.
  task automatic issue(input bit do_trap, input bit do_mret, input logic [31:0] pc,
                       input logic [31:0] cause, input logic [31:0] tval, input int gap);
    int t;
    wait_idle(gap);
    trap_req = do_trap; mret_req = do_mret;
    trap_pc = pc; trap_cause = cause; trap_tval = tval;
    tick();
    t = cyc;
    if (do_trap) begin
      model_trap(t, pc, cause, tval);
      trap_req = 1'b0;
      trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom;
      if (do_mret) begin
        model_mret(model_idle + 1);
        while (cyc < model_idle - 3) tick();
        mret_req = 1'b0;
      end
    end else if (do_mret) begin
      model_mret(t);
      mret_req = 1'b0;
    end
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < MAXC; i++) busy_map[i] = 1'b0;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    model_idle = cyc;
    repeat (5) tick();

    issue(1'b1, 1'b0, 32'h0000_1004, 32'd2, 32'hDEAD_BEEF, 0);
    wait_idle(1);
    chk("mepc_readback", csr_mem[12'h341], 32'h0000_1004);
    chk("mtval_readback", csr_mem[12'h343], 32'hDEAD_BEEF);

    issue(1'b1, 1'b0, 32'h0000_2007, 32'd4, 32'h0, 1);
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 0);

    issue(1'b1, 1'b1, 32'h0000_3000, 32'd5, 32'h1, 2);

    issue(1'b1, 1'b0, 32'h0000_4000, 32'h8000_0007, 32'h55, 0);
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 0);

    // Reset while mcause is being written: sequence abandoned, mepc kept.
    wait_idle(1);
    trap_req = 1'b1; trap_pc = 32'h0000_5008; trap_cause = 32'd11; trap_tval = 32'h77;
    tick();
    t = cyc;
    model_trap(t, 32'h0000_5008, 32'd11, 32'h77);
    trap_req = 1'b0;
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    csr_q.delete();
    rd_q.delete();
    for (int c = t + 2; c < t + 8; c++) busy_map[c] = 1'b0;
    last_rpc = '0;
    model_idle = t + 2;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mepc_after_reset", csr_mem[12'h341], 32'h0000_5008);
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [31:0] cause;
      kind = int'($urandom_range(0, 2));
      cause = $urandom;
      if ($urandom_range(0, 1) == 0) cause[31] = 1'b0;
      issue(kind != 1, kind != 0, $urandom, cause, $urandom, int'($urandom_range(0, 3)));
    end

    wait_idle(3);
    chk("final_mepc", csr_mem[12'h341], ref_mepc);
    chk("csr_queue_drained", csr_q.size(), 32'd0);
    chk("redirect_queue_drained", rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_seq.md
# trap_seq

Machine-mode trap sequencer: the initiator side of the CSR register-file port. On a trap request it writes `mepc`, `mcause` and `mtval` through the single-port CSR interface, then redirects the fetch unit to the trap vector. On `mret` it reads `mepc` back and redirects to the saved PC. It sits between the pipeline's exception/`mret` detection and the CSR register file.

## Interface
Parameters:
- `TRAP_VECTOR`, 32'h0000_0010, redirect target for every trap.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `trap_req` in 1: trap request; sampled only in IDLE.
- `trap_pc` in 32: faulting PC, written to `mepc`.
- `trap_cause` in 32: written to `mcause`; bit 31 set means interrupt.
- `trap_tval` in 32: written to `mtval`.
- `mret_req` in 1: return request; sampled only in IDLE.
- `csr_addr` out 12: CSR address (`mepc` 12'h341, `mcause` 12'h342, `mtval` 12'h343, `mip` 12'h344).
- `csr_op` out 2: `CSR_NOP`/`CSR_WRITE`/`CSR_SET`/`CSR_CLEAR` (control.vh encodings).
- `csr_wdata` out 32: CSR write data.
- `csr_rdata` in 32: registered CSR read data; valid the cycle after `csr_addr` is presented.
- `busy` out 1: high whenever state ≠ IDLE.
- `redirect_valid` out 1: one-cycle pulse; fetch must load `redirect_pc`.
- `redirect_pc` out 32: redirect target; holds its last value between pulses.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_MIP (macro only), R_EPC, R_WAIT, REDIRECT.
- A request is accepted when it is high in IDLE. Requests outside IDLE are ignored; the requester holds its request until `busy` falls.
- On acceptance, `trap_pc`/`trap_cause`/`trap_tval` are latched internally. Later changes on those inputs have no effect.
- Simultaneous `trap_req` and `mret_req`: the trap wins and `mret_req` is ignored.
- Trap path: IDLE → W_EPC (WRITE `mepc` ← pc) → W_CAUSE (WRITE `mcause` ← cause) → W_TVAL (WRITE `mtval` ← tval) → [W_MIP] → REDIRECT (`redirect_pc` ← `TRAP_VECTOR`) → IDLE.
- Mret path: IDLE → R_EPC (`csr_addr`=`mepc`, `csr_op`=`CSR_NOP`) → R_WAIT (capture `csr_rdata` & 32'hFFFF_FFFC) → REDIRECT → IDLE.
- In IDLE, R_EPC, R_WAIT and REDIRECT, `csr_op`=`CSR_NOP` and `csr_wdata`=0. `csr_addr`=0 except in R_EPC/R_WAIT, where it is 12'h341.
- CSR outputs are combinational from state and latched payloads. `redirect_pc` and state are registered.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, `busy`=0, `redirect_valid`=0, `redirect_pc`=0, `csr_op`=`CSR_NOP`, `csr_addr`=0, `csr_wdata`=0.
- Reset mid-sequence abandons the sequence. CSR writes already committed stay; no redirect is issued.
- Trap accepted at edge T: W_EPC during T..T+1 (write commits at edge T+1), W_CAUSE at T+1, W_TVAL at T+2, REDIRECT at T+3 (`redirect_valid`=1), IDLE at T+4. Total latency is 4 cycles, or 5 with W_MIP.
- Mret accepted at edge T: R_EPC at T, R_WAIT at T+1 (`csr_rdata` valid, captured at edge T+2), REDIRECT at T+2, IDLE at T+3.
- Back-to-back: a request held high is accepted on the IDLE cycle immediately after REDIRECT. Minimum trap-to-trap spacing is 5 cycles.
- `busy` rises the cycle after acceptance and falls in the cycle state returns to IDLE.

## Configuration
- `TRAP_SEQ_MIP_EN` defined:
  - For traps with latched cause bit 31 = 1, W_MIP follows W_TVAL and issues `CSR_CLEAR` on `mip` with `csr_wdata` = 32'h1 << cause[4:0].
  - For exceptions (bit 31 = 0), W_MIP is skipped.
- Not defined: the W_MIP state does not exist, `mip` is never accessed, and interrupt traps take the same 4-cycle path as exceptions.

## Test plan
- Reset then idle 5 cycles → `busy`=0, `redirect_valid`=0, `redirect_pc`=0, `csr_op`=`CSR_NOP` throughout.
- `trap_req` with pc=32'h0000_1004, cause=2, tval=32'hDEAD_BEEF → WRITE 0x341/0x342/0x343 on consecutive cycles with those values, then `redirect_valid` pulse with `redirect_pc`=32'h10. A CSR readback model shows `mepc`=32'h1004.
- `mret_req` after `mepc` holds 32'h0000_2007 → R_EPC drives 0x341 with NOP, then `redirect_pc`=32'h0000_2004 pulsed exactly 3 cycles after acceptance.
- `trap_req` and `mret_req` both high in IDLE → trap sequence only; `redirect_pc`=`TRAP_VECTOR`; the held `mret_req` is accepted on the following IDLE cycle.
- `rst_n` low during W_CAUSE → next cycle IDLE with all outputs at reset values. `mepc` keeps the written pc and no redirect pulse occurs.
- With `TRAP_SEQ_MIP_EN`, cause=32'h8000_0007 → after W_TVAL, `CSR_CLEAR` on 0x344 with wdata=32'h80, redirect 5 cycles after acceptance. Without the macro, the redirect comes after 4 cycles and there is no 0x344 access.
